// File: rtl/dmem_wt_cache.sv
// Direct-mapped, one-word-line, write-through / no-write-allocate data cache
// sitting between a processor dmem port and a backing memory.
package dmem_wt_cache_pkg;
  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  localparam logic [2:0] MEM_READ    = 3'd0;
  localparam logic [2:0] MEM_WRITE   = 3'd1;
  localparam logic [2:0] MEM_INIT    = 3'd2;
  localparam logic [2:0] MEM_AMO_ADD = 3'd3;
endpackage

// Handshakes: a transfer happens on a rising edge where val && rdy; the sender
// holds msg stable and val high until that edge, and val never depends on rdy.
module dmem_wt_cache
  import dmem_wt_cache_pkg::*;
#(
  parameter int p_num_entries = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  mem_req_4B_t  procreq_msg,
  input  logic         procreq_val,
  output logic         procreq_rdy,
  output mem_resp_4B_t procresp_msg,
  output logic         procresp_val,
  input  logic         procresp_rdy,
  output mem_req_4B_t  memreq_msg,
  output logic         memreq_val,
  input  logic         memreq_rdy,
  input  mem_resp_4B_t memresp_msg,
  input  logic         memresp_val,
  output logic         memresp_rdy,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count,
  output logic [2:0]   dbg_state
);
  localparam int IW = $clog2(p_num_entries);
  localparam int TW = 30 - IW;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_MREQ   = 3'd2;
  localparam logic [2:0] S_MWAIT  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]               state_q, state_d;
  mem_req_4B_t              req_q, req_d;
  logic [31:0]              resp_data_q, resp_data_d;
  logic [31:0]              hit_q, hit_d, miss_q, miss_d;
  logic [p_num_entries-1:0] valid_q, valid_d;
  logic [TW-1:0]            tag_q  [p_num_entries];
  logic [31:0]              data_q [p_num_entries];

  logic          line_we;
  logic [31:0]   line_data;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          cacheable, line_hit;
  logic          unused_memresp;

  assign idx       = req_q.addr[IW+1:2];
  assign tag       = req_q.addr[31:IW+2];
  assign cacheable = ((req_q.type_ == MEM_READ) || (req_q.type_ == MEM_WRITE)) &&
                     (req_q.len == 2'd0) && (req_q.addr[1:0] == 2'b00);
  assign line_hit  = valid_q[idx] && (tag_q[idx] == tag);

  assign unused_memresp = ^{memresp_msg.type_, memresp_msg.opaque,
                            memresp_msg.test, memresp_msg.len};

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    resp_data_d  = resp_data_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    valid_d      = valid_q;
    line_we      = 1'b0;
    line_data    = req_q.data;
    procreq_rdy  = 1'b0;
    memreq_val   = 1'b0;
    memresp_rdy  = 1'b0;
    procresp_val = 1'b0;
    case (state_q)
      S_IDLE: begin
        procreq_rdy = 1'b1;
        if (procreq_val) begin
          req_d   = procreq_msg;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        state_d = S_MREQ;
        if (cacheable && (req_q.type_ == MEM_READ)) begin
          if (line_hit) begin
            resp_data_d = data_q[idx];
            hit_d       = hit_q + 32'd1;
            state_d     = S_RESP;
          end else begin
            miss_d = miss_q + 32'd1;
          end
        end else if (cacheable) begin
          line_we = line_hit;
        end else if (line_hit) begin
          // Uncached access may change the word behind our back: drop the copy.
          valid_d[idx] = 1'b0;
        end
      end
      S_MREQ: begin
        memreq_val = 1'b1;
        if (memreq_rdy) state_d = S_MWAIT;
      end
      S_MWAIT: begin
        memresp_rdy = 1'b1;
        if (memresp_val) begin
          resp_data_d = (req_q.type_ == MEM_WRITE) ? 32'd0 : memresp_msg.data;
          if (cacheable && (req_q.type_ == MEM_READ)) begin
            line_we      = 1'b1;
            line_data    = memresp_msg.data;
            valid_d[idx] = 1'b1;
          end
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        procresp_val = 1'b1;
        if (procresp_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  always_ff @(posedge clk) begin
    req_q       <= req_d;
    resp_data_q <= resp_data_d;
    if (line_we && reset) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= line_data;
    end
  end

  always_comb begin
    procresp_msg        = '0;
    procresp_msg.type_  = req_q.type_;
    procresp_msg.opaque = req_q.opaque;
    procresp_msg.len    = req_q.len;
    procresp_msg.data   = resp_data_q;
  end

  assign memreq_msg = req_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_dmem_wt_cache.sv
// Directed bench for dmem_wt_cache: expected responses and memory requests are
// queued by the driver and consumed by independent monitor/responder processes.
module tb_dmem_wt_cache;
  import dmem_wt_cache_pkg::*;

  localparam int RESP_W = $bits(mem_resp_4B_t);
  localparam int REQ_W  = $bits(mem_req_4B_t);

  logic         clk = 1'b0;
  logic         reset;
  mem_req_4B_t  procreq_msg;
  logic         procreq_val, procreq_rdy;
  mem_resp_4B_t procresp_msg;
  logic         procresp_val, procresp_rdy;
  mem_req_4B_t  memreq_msg;
  logic         memreq_val, memreq_rdy;
  mem_resp_4B_t memresp_msg;
  logic         memresp_val, memresp_rdy;
  logic [31:0]  hit_count, miss_count;
  logic [2:0]   dbg_state;

  logic [RESP_W-1:0] exp_q[$];
  logic [REQ_W-1:0]  exp_mreq_q[$];
  logic [31:0]       mem [logic [31:0]];
  int                n_checks = 0;
  int                n_pass   = 0;
  logic [7:0]        opq      = 8'h10;

  dmem_wt_cache #(.p_num_entries(16)) dut (
    .clk(clk), .reset(reset),
    .procreq_msg(procreq_msg), .procreq_val(procreq_val), .procreq_rdy(procreq_rdy),
    .procresp_msg(procresp_msg), .procresp_val(procresp_val), .procresp_rdy(procresp_rdy),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
    .hit_count(hit_count), .miss_count(miss_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // response monitor
  always @(negedge clk) begin
    if (procresp_val && procresp_rdy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_resp: actual %0h required none", procresp_msg);
      end else begin
        check("procresp_msg", procresp_msg, exp_q.pop_front());
      end
    end
  end

  // backing memory: checks forwarded requests, answers with zero wait
  always @(negedge clk) begin
    if (memreq_val && memreq_rdy) begin
      logic [31:0] old;
      if (exp_mreq_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_memreq: actual %0h required none", memreq_msg);
      end else begin
        check("memreq_msg", memreq_msg, exp_mreq_q.pop_front());
      end
      old = mem.exists(memreq_msg.addr) ? mem[memreq_msg.addr] : 32'd0;
      if (memreq_msg.type_ == MEM_WRITE) mem[memreq_msg.addr] = memreq_msg.data;
      if (memreq_msg.type_ == MEM_AMO_ADD) mem[memreq_msg.addr] = old + memreq_msg.data;
      memresp_msg        = '0;
      memresp_msg.type_  = memreq_msg.type_;
      memresp_msg.opaque = memreq_msg.opaque;
      memresp_msg.len    = memreq_msg.len;
      memresp_msg.data   = (memreq_msg.type_ == MEM_WRITE) ? 32'd0 : old;
    end
  end

  // driver tasks: entered and left at posedge+1
  task automatic send_req(input logic [2:0] t, input logic [31:0] a, input logic [1:0] l,
                          input logic [31:0] d, input bit exp_mem, input bit exp_resp,
                          input logic [31:0] rdata);
    mem_req_4B_t  r;
    mem_resp_4B_t e;
    bit           acc;
    r.type_ = t; r.opaque = opq; r.addr = a; r.len = l; r.data = d;
    opq = opq + 8'd1;
    if (exp_mem) exp_mreq_q.push_back(r);
    if (exp_resp) begin
      e.type_ = t; e.opaque = r.opaque; e.test = 2'd0; e.len = l; e.data = rdata;
      exp_q.push_back(e);
    end
    procreq_msg = r;
    procreq_val = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (procreq_rdy) acc = 1'b1;
    end
    if (!acc) check("req_accept_timeout", 0, 1);
    @(posedge clk); #1;
    procreq_val = 1'b0;
  endtask

  task automatic wait_resp(input int exp_lat, input string name);
    int cyc;
    bit got;
    cyc = 0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (procresp_val) got = 1'b1;
    end
    if (!got) check({name, "_resp_timeout"}, 0, 1);
    else if (exp_lat != 0) check({name, "_latency"}, cyc, exp_lat);
  endtask

  task automatic txn(input logic [2:0] t, input logic [31:0] a, input logic [1:0] l,
                     input logic [31:0] d, input bit exp_mem, input logic [31:0] rdata,
                     input int lat, input string name);
    send_req(t, a, l, d, exp_mem, 1'b1, rdata);
    wait_resp(lat, name);
    @(posedge clk); #1;
  endtask

  initial begin
    mem_req_4B_t  held_req;
    mem_resp_4B_t held_resp;
    int           bad;
    bit           seen;

    reset        = 1'b0;
    procreq_val  = 1'b0;
    procreq_msg  = '0;
    procresp_rdy = 1'b1;
    memreq_rdy   = 1'b1;
    memresp_val  = 1'b1;
    memresp_msg  = '0;
    mem[32'h1000] = 32'hDEADBEEF;
    mem[32'h1040] = 32'hCAFEF00D;
    mem[32'h2000] = 32'h11112222;

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_procreq_rdy", procreq_rdy, 1);
    check("rst_memreq_val", memreq_val, 0);
    check("rst_memresp_rdy", memresp_rdy, 0);
    check("rst_procresp_val", procresp_val, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_miss_count", miss_count, 0);
    @(posedge clk); #1;

    // cold miss, then hit
    txn(MEM_READ, 32'h1000, 2'd0, 32'd0, 1'b1, 32'hDEADBEEF, 4, "cold_read");
    check("miss_after_cold", miss_count, 1);
    txn(MEM_READ, 32'h1000, 2'd0, 32'd0, 1'b0, 32'hDEADBEEF, 2, "hit_read");
    check("hit_after_hit", hit_count, 1);

    // write-through on hit updates the line
    txn(MEM_WRITE, 32'h1000, 2'd0, 32'h12345678, 1'b1, 32'd0, 4, "write_hit");
    check("hit_after_write", hit_count, 1);
    check("miss_after_write", miss_count, 1);
    txn(MEM_READ, 32'h1000, 2'd0, 32'd0, 1'b0, 32'h12345678, 2, "read_after_write");
    check("hit_after_rw", hit_count, 2);

    // conflict on index 0
    txn(MEM_READ, 32'h1040, 2'd0, 32'd0, 1'b1, 32'hCAFEF00D, 4, "conflict_a");
    txn(MEM_READ, 32'h1000, 2'd0, 32'd0, 1'b1, 32'h12345678, 4, "conflict_b");
    check("miss_after_conflict", miss_count, 3);
    check("hit_after_conflict", hit_count, 2);

    // AMO passes through and invalidates
    txn(MEM_AMO_ADD, 32'h1000, 2'd0, 32'd1, 1'b1, 32'h12345678, 4, "amo");
    txn(MEM_READ, 32'h1000, 2'd0, 32'd0, 1'b1, 32'h12345679, 4, "read_after_amo");
    txn(MEM_READ, 32'h1000, 2'd0, 32'd0, 1'b0, 32'h12345679, 2, "refill_hit");
    check("miss_after_amo", miss_count, 4);
    check("hit_after_amo", hit_count, 3);

    // len=1 read is uncached and invalidates
    txn(MEM_READ, 32'h1000, 2'd1, 32'd0, 1'b1, 32'h12345679, 4, "len1_read");
    txn(MEM_READ, 32'h1000, 2'd0, 32'd0, 1'b1, 32'h12345679, 4, "read_after_len1");
    check("miss_after_len1", miss_count, 5);
    check("hit_after_len1", hit_count, 3);

    // response back-pressure
    procresp_rdy = 1'b0;
    send_req(MEM_READ, 32'h1000, 2'd0, 32'd0, 1'b0, 1'b1, 32'h12345679);
    wait_resp(2, "stall_hit");
    held_resp = procresp_msg;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!procresp_val || procresp_msg !== held_resp || procreq_rdy !== 1'b0) bad++;
    end
    check("resp_stall_stable", bad, 0);
    @(posedge clk); #1;
    procresp_rdy = 1'b1;
    @(posedge clk); #1;
    check("hit_after_stall", hit_count, 4);

    // memory request back-pressure
    memreq_rdy = 1'b0;
    send_req(MEM_READ, 32'h2000, 2'd0, 32'd0, 1'b1, 1'b1, 32'h11112222);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (memreq_val) seen = 1'b1;
    end
    check("memreq_seen", seen, 1);
    held_req = memreq_msg;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (!memreq_val || memreq_msg !== held_req) bad++;
    end
    check("memreq_stall_stable", bad, 0);
    @(posedge clk); #1;
    memreq_rdy = 1'b1;
    wait_resp(0, "memreq_stall");
    @(posedge clk); #1;
    check("miss_after_mstall", miss_count, 6);

    // reset while waiting on memory abandons the request
    memresp_val = 1'b0;
    send_req(MEM_READ, 32'h1040, 2'd0, 32'd0, 1'b1, 1'b0, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (memresp_rdy) seen = 1'b1;
    end
    check("reached_mwait", seen, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    memresp_val = 1'b1;
    @(negedge clk);
    check("mrst_state_idle", dbg_state, 0);
    check("mrst_procreq_rdy", procreq_rdy, 1);
    check("mrst_procresp_val", procresp_val, 0);
    check("mrst_memresp_rdy", memresp_rdy, 0);
    check("mrst_hit_count", hit_count, 0);
    check("mrst_miss_count", miss_count, 0);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    txn(MEM_READ, 32'h2000, 2'd0, 32'd0, 1'b1, 32'h11112222, 4, "read_after_rst");
    check("miss_after_rst", miss_count, 1);
    check("hit_after_rst", hit_count, 0);

    repeat (3) @(posedge clk);
    check("resp_queue_empty", exp_q.size(), 0);
    check("memreq_queue_empty", exp_mreq_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
